// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: transmitter states and framing constants shared by the Ethernet TX files.
package eth_tx_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, EOT, IFG} tx_state_e;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;
endpackage

// File: rtl/tx_timer.sv
// tx_timer: Manchester half-bit counter with half flag, bit-start and bit-done strobes.
module tx_timer #(
    parameter int CLKS_PER_HALF_BIT = 5
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    output logic half,
    output logic bit_start,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_HALF_BIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d, half_end;

    always_comb begin
        half_end  = cnt_q == CW'(CLKS_PER_HALF_BIT - 1);
        cnt_d     = !run || half_end ? '0 : cnt_q + CW'(1);
        half_d    = run && (half_end ? !half_q : half_q);
        half      = half_q;
        bit_start = run && cnt_q == '0 && !half_q;
        bit_done  = run && half_end && half_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end
endmodule

// File: rtl/ethernet_transmitter.sv
// ethernet_transmitter: serialises preamble, SFD and FIFO data bytes as a Manchester
// line, followed by an end-of-transmission pulse and the inter-frame gap.
module ethernet_transmitter
    import eth_tx_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 5,
    parameter int MAX_BYTES         = 1518,
    parameter int IFG_BITS          = 96
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       EMPTY,
    input  logic [7:0] T_Data,
    output logic       r_enable,
    output logic       Ethernet_Out,
    output logic       tx_busy,
    output logic       byte_sent
);
    localparam int PRE_BITS = PREAMBLE_LEN * 8;
    localparam int BCW      = $clog2((IFG_BITS > PRE_BITS ? IFG_BITS : PRE_BITS) + 1);

    tx_state_e      state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d, hold_q, hold_d;
    logic [10:0]    byte_cnt_q, byte_cnt_d;
    logic           pend_q, pend_d, rd_q, rd_d;
    logic           half, bit_start, bit_done;
    logic           serial, fetch_slot, byte_end, pre_end;

    tx_timer #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .run      (state_q != IDLE),
        .half     (half),
        .bit_start(bit_start),
        .bit_done (bit_done)
    );

    always_comb begin
        serial     = state_q inside {PREAMBLE, SFD, DATA};
        fetch_slot = state_q inside {SFD, DATA};
        byte_end   = bit_done && bit_cnt_q[2:0] == 3'd7;
        pre_end    = bit_done && bit_cnt_q == BCW'(PRE_BITS - 1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = EMPTY ? IDLE : PREAMBLE;
            PREAMBLE:  state_d = pre_end ? SFD : PREAMBLE;
            SFD, DATA: state_d = !byte_end ? state_q : pend_q ? DATA : EOT;
            EOT:       state_d = bit_done && bit_cnt_q == BCW'(1) ? IFG : EOT;
            IFG:       state_d = bit_done && bit_cnt_q == BCW'(IFG_BITS - 1) ? IDLE : IFG;
            default:   state_d = IDLE;
        endcase
    end

    // bit_cnt restarts on every state change; inside DATA only its low 3 bits matter
    always_comb begin
        bit_cnt_d  = state_d != state_q ? '0 : bit_cnt_q + BCW'(bit_done);
        shift_d    = state_q == IDLE ? PREAMBLE_BYTE
                   : !bit_done ? shift_q
                   : state_q == PREAMBLE && pre_end ? SFD_BYTE
                   : bit_cnt_q[2:0] != 3'd7 ? {1'b0, shift_q[7:1]}
                   : state_q == PREAMBLE ? PREAMBLE_BYTE : hold_q;
        rd_d       = r_enable;
        hold_d     = rd_q ? T_Data : hold_q;
        pend_d     = rd_q || (pend_q && !(fetch_slot && byte_end));
        byte_cnt_d = state_q == IDLE ? '0 : byte_cnt_q + 11'(fetch_slot && byte_end && pend_q);
    end

    always_comb begin
        tx_busy      = state_q != IDLE;
        r_enable     = fetch_slot && bit_start && bit_cnt_q[2:0] == 3'd7 && !EMPTY
                       && byte_cnt_q < 11'(MAX_BYTES);
        byte_sent    = state_q == DATA && byte_end;
        Ethernet_Out = state_q == EOT || (serial && (shift_q[0] ~^ half));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            byte_cnt_q <= '0;
            pend_q     <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            byte_cnt_q <= byte_cnt_d;
            pend_q     <= pend_d;
            rd_q       <= rd_d;
        end
    end
endmodule
